// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending controller: FSM state encoding and the
// default values of the controller parameters.
// Ports: none (package).
// Configuration: optional change dispenser enabled by defining VEND_CHANGE_EN.
// -----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // no credit
        ST_CREDIT = 2'd1,   // credit held, waiting for a purchase
        ST_VEND   = 2'd2,   // single dispense cycle
        ST_CHANGE = 2'd3    // returning remaining credit as change beats
    } vend_state_t;

    localparam int VEND_NUM_PROD = 4;   // selectable products
    localparam int VEND_SEL_W    = 2;   // product index width
    localparam int VEND_CREDIT_W = 8;   // credit / price width, 5-cent units
    localparam int VEND_COIN_W   = 3;   // coin value width, 5-cent units
    localparam int VEND_CHG_STEP = 1;   // max units returned per change beat

endpackage

// File: rtl/vend_price_mux.sv
// -----------------------------------------------------------------------------
// vend_price_mux
// Selects one product price out of the flattened price table.
// Ports:
//   price_tbl  in  NUM_PROD*CREDIT_W  price of product i at [i*CREDIT_W +: CREDIT_W]
//   idx        in  SEL_W              product index
//   price      out CREDIT_W           price of product idx (0 if idx out of range)
// Configuration: none (VEND_CHANGE_EN does not affect this block).
// -----------------------------------------------------------------------------
module vend_price_mux import vend_pkg::*; #(
    parameter int NUM_PROD = VEND_NUM_PROD,
    parameter int SEL_W    = VEND_SEL_W,
    parameter int CREDIT_W = VEND_CREDIT_W
) (
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    input  logic [SEL_W-1:0]             idx,
    output logic [CREDIT_W-1:0]          price
);

    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (idx == SEL_W'(i)) begin
                price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_p.sv
// -----------------------------------------------------------------------------
// vend_ctrl_p
// Vending machine controller: accumulates coin credit, latches a pending
// product selection, dispenses once credit covers the price and (optionally)
// returns the remainder through a ready/valid change dispenser.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   coin_valid/coin_val coin inserted this cycle and its value
//   sel_valid/sel       product selection request and index
//   cancel              abort purchase, refund credit
//   price_tbl           flattened price table
//   chg_ready           change dispenser accepts a beat
//   vend/vend_id        one-cycle dispense pulse and dispensed product
//   credit              current credit
//   coin_reject         one-cycle pulse, coin refused
//   sel_err             one-cycle pulse, selection index out of range
//   chg_valid/chg_amt   change beat offered to the dispenser
//   busy                high while vending or returning change
// Configuration: define VEND_CHANGE_EN to build the change dispenser. Without
// it the CHANGE state is never entered, chg_valid/chg_amt are tied to 0, any
// remainder stays as credit and cancel only clears the pending selection.
// -----------------------------------------------------------------------------
module vend_ctrl_p import vend_pkg::*; #(
    parameter int NUM_PROD = VEND_NUM_PROD,
    parameter int SEL_W    = VEND_SEL_W,
    parameter int CREDIT_W = VEND_CREDIT_W,
    parameter int COIN_W   = VEND_COIN_W,
    parameter int CHG_STEP = VEND_CHG_STEP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         coin_valid,
    input  logic [COIN_W-1:0]            coin_val,
    input  logic                         sel_valid,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         cancel,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    input  logic                         chg_ready,
    output logic                         vend,
    output logic [SEL_W-1:0]             vend_id,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         sel_err,
    output logic                         chg_valid,
    output logic [CREDIT_W-1:0]          chg_amt,
    output logic                         busy
);

    vend_state_t          state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [SEL_W-1:0]     pend_idx_q, pend_idx_d;
    logic                 vend_q, vend_d;
    logic [SEL_W-1:0]     vend_id_q, vend_id_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_err_q, sel_err_d;
    logic                 busy_q, busy_d;

    logic                 coin_live;
    logic [CREDIT_W:0]    coin_sum;
    logic                 sel_in_range;
    logic [SEL_W-1:0]     price_idx;
    logic [CREDIT_W-1:0]  price;

    // A zero-valued coin is treated as no coin at all.
    assign coin_live    = coin_valid && (coin_val != '0);
    // Extra carry bit: a set MSB means the coin would overflow the credit.
    assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
    assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_PROD));
    // Price lookup uses the selection that will be pending after this edge,
    // so a same-cycle selection and coin can vend immediately.
    assign price_idx    = (sel_valid && sel_in_range) ? sel : pend_idx_q;

    vend_price_mux #(
        .NUM_PROD (NUM_PROD),
        .SEL_W    (SEL_W),
        .CREDIT_W (CREDIT_W)
    ) u_price_mux (
        .price_tbl (price_tbl),
        .idx       (price_idx),
        .price     (price)
    );

`ifdef VEND_CHANGE_EN
    localparam logic [CREDIT_W-1:0] STEP = CREDIT_W'(CHG_STEP);

    logic                 chg_valid_q, chg_valid_d;
    logic [CREDIT_W-1:0]  chg_amt_q, chg_amt_d;

    function automatic logic [CREDIT_W-1:0] min_step(input logic [CREDIT_W-1:0] c);
        return (c < STEP) ? c : STEP;
    endfunction
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d       = state_q;
        credit_d      = credit_q;
        pend_valid_d  = pend_valid_q;
        pend_idx_d    = pend_idx_q;
        vend_d        = 1'b0;
        vend_id_d     = '0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
`ifdef VEND_CHANGE_EN
        chg_valid_d   = 1'b0;
        chg_amt_d     = '0;
`endif

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    // Cancel wins: a same-cycle coin is refused, selection ignored.
                    coin_reject_d = coin_live;
                    pend_valid_d  = 1'b0;
`ifdef VEND_CHANGE_EN
                    if (credit_q != '0) begin
                        state_d     = ST_CHANGE;
                        chg_valid_d = 1'b1;
                        chg_amt_d   = min_step(credit_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    if (coin_live) begin
                        if (coin_sum[CREDIT_W]) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end
                    end
                    if (sel_valid) begin
                        if (sel_in_range) begin
                            pend_valid_d = 1'b1;
                            pend_idx_d   = sel;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                    state_d = (credit_d == '0) ? ST_IDLE : ST_CREDIT;
                    // Re-evaluated every cycle, so a zero price vends on selection.
                    if (pend_valid_d && (credit_d >= price)) begin
                        vend_d       = 1'b1;
                        vend_id_d    = pend_idx_d;
                        credit_d     = credit_d - price;
                        pend_valid_d = 1'b0;
                        state_d      = ST_VEND;
                    end
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_live;
`ifdef VEND_CHANGE_EN
                if (credit_q != '0) begin
                    state_d     = ST_CHANGE;
                    chg_valid_d = 1'b1;
                    chg_amt_d   = min_step(credit_q);
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = (credit_q == '0) ? ST_IDLE : ST_CREDIT;
`endif
            end

            ST_CHANGE: begin
`ifdef VEND_CHANGE_EN
                coin_reject_d = coin_live;
                chg_valid_d   = 1'b1;
                chg_amt_d     = chg_amt_q;
                // chg_valid is always high here, so chg_ready alone completes a beat.
                if (chg_ready) begin
                    credit_d = credit_q - chg_amt_q;
                    if (credit_d == '0) begin
                        state_d     = ST_IDLE;
                        chg_valid_d = 1'b0;
                        chg_amt_d   = '0;
                    end else begin
                        chg_amt_d = min_step(credit_d);
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_idx_q    <= '0;
            vend_q        <= 1'b0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge
            // values, independent of statement order.
            state_q       <= state_d;
            credit_q      <= credit_d;
            pend_valid_q  <= pend_valid_d;
            pend_idx_q    <= pend_idx_d;
            vend_q        <= vend_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
        end
    end

`ifdef VEND_CHANGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_valid_q <= 1'b0;
            chg_amt_q   <= '0;
        end else begin
            chg_valid_q <= chg_valid_d;
            chg_amt_q   <= chg_amt_d;
        end
    end

    assign chg_valid = chg_valid_q;
    assign chg_amt   = chg_amt_q;
`else
    logic unused_chg_ready;
    assign unused_chg_ready = chg_ready;
    assign chg_valid        = 1'b0;
    assign chg_amt          = '0;
`endif

    assign vend        = vend_q;
    assign vend_id     = vend_id_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/vend_ctrl_p.md
VEND_CTRL_P -- requirements
Module: vend_ctrl_p

Interface
REQ-001 SHALL have parameter NUM_PROD, default 4, number of selectable products.
REQ-002 SHALL have parameter SEL_W, default 2, product-select width; SHALL satisfy 2**SEL_W >= NUM_PROD.
REQ-003 SHALL have parameter CREDIT_W, default 8, credit/price width in 5-cent units.
REQ-004 SHALL have parameter COIN_W, default 3, coin value width in 5-cent units.
REQ-005 SHALL have parameter CHG_STEP, default 1, maximum units returned per change beat (>=1).
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port coin_valid  in  1  coin present this cycle.
REQ-009 SHALL have port coin_val  in  COIN_W  coin value.
REQ-010 SHALL have port sel_valid  in  1  product selection request.
REQ-011 SHALL have port sel  in  SEL_W  selected product index.
REQ-012 SHALL have port cancel  in  1  abort purchase, refund.
REQ-013 SHALL have port price_tbl  in  NUM_PROD*CREDIT_W  price of product i at bits [i*CREDIT_W +: CREDIT_W].
REQ-014 SHALL have port chg_ready  in  1  change dispenser accepts beat.
REQ-015 SHALL have port vend  out  1  one-cycle dispense pulse.
REQ-016 SHALL have port vend_id  out  SEL_W  product dispensed, valid with vend.
REQ-017 SHALL have port credit  out  CREDIT_W  current credit.
REQ-018 SHALL have port coin_reject  out  1  one-cycle pulse, coin refused.
REQ-019 SHALL have port sel_err  out  1  one-cycle pulse, sel >= NUM_PROD.
REQ-020 SHALL have ports chg_valid  out  1 and chg_amt  out  CREDIT_W  change beat.
REQ-021 SHALL have port busy  out  1  high in VEND or CHANGE.

Function
REQ-022 SHALL implement states IDLE, CREDIT, VEND, CHANGE; all outputs registered; response appears cycle after qualifying input.
REQ-023 Coin in IDLE/CREDIT SHALL add coin_val to credit if sum <= 2**CREDIT_W-1, else pulse coin_reject with credit unchanged; coin_val 0 ignored; coins in VEND/CHANGE rejected.
REQ-024 Valid sel SHALL be latched as pending; any later sel_valid replaces it; sel >= NUM_PROD pulses sel_err, pending unchanged.
REQ-025 Whenever pending exists and credit (including same-cycle coin) >= price, SHALL enter VEND: vend=1, vend_id=pending, credit -= price, pending cleared.
REQ-026 Price 0 SHALL vend on selection regardless of credit.
REQ-027 VEND SHALL last one cycle, then CHANGE if remaining credit > 0, else IDLE.
REQ-028 cancel SHALL have priority over same-cycle coin (rejected) and sel (ignored); clears pending; goes CHANGE if credit > 0 else IDLE; ignored in VEND/CHANGE.
REQ-029 CHANGE: chg_valid=1, chg_amt=min(credit,CHG_STEP), held stable until chg_valid&chg_ready; each handshake subtracts chg_amt; credit 0 -> IDLE same edge.
REQ-030 sel_valid in VEND/CHANGE SHALL be ignored without sel_err.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, credit 0, pending cleared, all outputs 0, independent of clk.

Configuration
REQ-032 With VEND_CHANGE_EN defined, SHALL behave per REQ-027..029.
REQ-033 Without VEND_CHANGE_EN, CHANGE SHALL not exist: chg_valid/chg_amt tied 0, remainder after vend stays as credit (state CREDIT), cancel only clears pending.

Structure
REQ-034 Package vend_pkg SHALL hold state encoding typedef and default parameter constants.
REQ-035 Sub-module vend_price_mux SHALL select price from price_tbl by index.

Verification (defaults, prices 3/5/6/7, VEND_CHANGE_EN defined)
REQ-036 Coins 2 then 1, sel 0 -> vend=1, vend_id=0, credit=0, IDLE, no chg_valid.
REQ-037 sel 3 at credit 0, coins 4, 4 -> vend after second coin, credit 1, one chg beat amt 1.
REQ-038 Credit 250, coin 7 -> coin_reject pulse, credit 250.
REQ-039 Credit 6, cancel, chg_ready low 3 cycles -> chg_valid/chg_amt=1 held, then 6 beats, IDLE.
REQ-040 NUM_PROD=3, sel 3 -> sel_err pulse, no vend, pending unchanged.
REQ-041 rst_n low mid-CHANGE -> credit 0, chg_valid 0 before next clk edge.
